regfile_sb: RTL and testbench

Parametrised integer register file with a tagged busy scoreboard, the successor to the plain architectural register file in the pipeline. It supports configurable depth, width and port counts, same-cycle write-to-read bypass, and deterministic multi-port write priority. It tracks per-register producer tags so issue logic can stall on RAW hazards and resolve WAW hazards, and supports a pipeline flush that clears all pending producers. It sits between decode/issue (read, issue) and writeback (write, clear).

---
 rtl/regfile_sb_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 90 +++++++++
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared register-file types and port-count defaults for the integer pipeline.
package regfile_sb_pkg;

    localparam int AREG_NREGS       = 32;
    localparam int AREG_XLEN        = 64;
    localparam int AREG_READ_PORTS  = 2;
    localparam int AREG_WRITE_PORTS = 2;
    localparam int AREG_ISSUE_PORTS = 2;
    localparam int SB_TAG_W         = 4;

    typedef logic [$clog2(AREG_NREGS)-1:0] creg_addr_t;
    typedef logic [63:0]                   u64;
    typedef logic [SB_TAG_W-1:0]           sb_tag_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy/tag scoreboard: issue sets, tag-matched writeback clears,
// flush clears all, and lookups see a same-cycle matching writeback as done.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS       = AREG_NREGS,
    parameter int NLOOK       = 2 * AREG_READ_PORTS,
    parameter int WRITE_PORTS = AREG_WRITE_PORTS,
    parameter int ISSUE_PORTS = AREG_ISSUE_PORTS,
    parameter int TAG_W       = SB_TAG_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NLOOK-1:0][$clog2(NREGS)-1:0]         la,
    output logic [NLOOK-1:0]                            lbusy,
    output logic [NLOOK-1:0][TAG_W-1:0]                 ltag,
    input  logic [WRITE_PORTS-1:0][$clog2(NREGS)-1:0]   wa,
    input  logic [WRITE_PORTS-1:0]                      wvalid,
    input  logic [WRITE_PORTS-1:0][TAG_W-1:0]           wtag,
    input  logic [ISSUE_PORTS-1:0][$clog2(NREGS)-1:0]   ia,
    input  logic [ISSUE_PORTS-1:0]                      ivalid,
    input  logic [ISSUE_PORTS-1:0][TAG_W-1:0]           itag,
    input  logic                                        flush
);

    localparam int AW = $clog2(NREGS);

    logic             busy_q [NREGS];
    logic             busy_d [NREGS];
    logic [TAG_W-1:0] tag_q  [NREGS];
    logic [TAG_W-1:0] tag_d  [NREGS];

    // Order matters: clear, then issue (later issue ports override), then flush.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];
        end
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
        for (int i = 1; i < NREGS; i++) begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && wa[j] == AW'(i) && busy_q[i] && wtag[j] == tag_q[i]) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end
            for (int k = 0; k < ISSUE_PORTS; k++) begin
                if (ivalid[k] && ia[k] == AW'(i)) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = itag[k];
                end
            end
            if (flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    always_comb begin
        for (int l = 0; l < NLOOK; l++) begin
            lbusy[l] = 1'b0;
            ltag[l]  = '0;
            if (la[l] != '0 && busy_q[la[l]]) begin
                lbusy[l] = 1'b1;
                ltag[l]  = tag_q[la[l]];
                for (int j = 0; j < WRITE_PORTS; j++) begin
                    if (wvalid[j] && wa[j] == la[l] && wtag[j] == tag_q[la[l]]) begin
                        lbusy[l] = 1'b0;
                        ltag[l]  = '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and a tagged busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int NREGS       = AREG_NREGS,
    parameter int XLEN        = AREG_XLEN,
    parameter int READ_PORTS  = AREG_READ_PORTS,
    parameter int WRITE_PORTS = AREG_WRITE_PORTS,
    parameter int ISSUE_PORTS = AREG_ISSUE_PORTS,
    parameter int TAG_W       = SB_TAG_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [READ_PORTS-1:0][$clog2(NREGS)-1:0]    rs1,
    input  logic [READ_PORTS-1:0][$clog2(NREGS)-1:0]    rs2,
    output logic [READ_PORTS-1:0][XLEN-1:0]             rd1,
    output logic [READ_PORTS-1:0][XLEN-1:0]             rd2,
    output logic [READ_PORTS-1:0]                       rbusy1,
    output logic [READ_PORTS-1:0]                       rbusy2,
    output logic [READ_PORTS-1:0][TAG_W-1:0]            rtag1,
    output logic [READ_PORTS-1:0][TAG_W-1:0]            rtag2,
    input  logic [WRITE_PORTS-1:0][$clog2(NREGS)-1:0]   wa,
    input  logic [WRITE_PORTS-1:0]                      wvalid,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]            wd,
    input  logic [WRITE_PORTS-1:0][TAG_W-1:0]           wtag,
    input  logic [ISSUE_PORTS-1:0][$clog2(NREGS)-1:0]   ia,
    input  logic [ISSUE_PORTS-1:0]                      ivalid,
    input  logic [ISSUE_PORTS-1:0][TAG_W-1:0]           itag,
    input  logic                                        flush
);

    localparam int AW    = $clog2(NREGS);
    localparam int NLOOK = 2 * READ_PORTS;

    // rs1 ports occupy the low lookup slots, rs2 ports the high ones.
    logic [NLOOK-1:0][AW-1:0]    la;
    logic [NLOOK-1:0][XLEN-1:0]  ld;
    logic [NLOOK-1:0]            lbusy;
    logic [NLOOK-1:0][TAG_W-1:0] ltag;
    logic [XLEN-1:0]             mem_q [NREGS];

    assign la     = {rs2, rs1};
    assign rd1    = ld[READ_PORTS-1:0];
    assign rd2    = ld[NLOOK-1:READ_PORTS];
    assign rbusy1 = lbusy[READ_PORTS-1:0];
    assign rbusy2 = lbusy[NLOOK-1:READ_PORTS];
    assign rtag1  = ltag[READ_PORTS-1:0];
    assign rtag2  = ltag[NLOOK-1:READ_PORTS];

    // NOTE: the array is cleared by reset only because the pipeline expects
    // every register to read 0 afterwards; a plain storage RAM would not be.
    // Later ports overwrite earlier ones within the loop, giving highest-index priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && wa[j] != '0) mem_q[wa[j]] <= wd[j];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NLOOK; l++) begin
            ld[l] = mem_q[la[l]];
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && wa[j] == la[l]) ld[l] = wd[j];
            end
            if (la[l] == '0) ld[l] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS       (NREGS),
        .NLOOK       (NLOOK),
        .WRITE_PORTS (WRITE_PORTS),
        .ISSUE_PORTS (ISSUE_PORTS),
        .TAG_W       (TAG_W)
    ) u_scoreboard (
        .clk    (clk),
        .reset  (reset),
        .la     (la),
        .lbusy  (lbusy),
        .ltag   (ltag),
        .wa     (wa),
        .wvalid (wvalid),
        .wtag   (wtag),
        .ia     (ia),
        .ivalid (ivalid),
        .itag   (itag),
        .flush  (flush)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, write priority, scoreboard WAW/flush/reset.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    creg_addr_t [1:0] rs1, rs2, wa, ia;
    u64 [1:0]       rd1, rd2, wd;
    logic [1:0]     rbusy1, rbusy2, wvalid, ivalid;
    sb_tag_t [1:0]  rtag1, rtag2, wtag, itag;
    logic           flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .rtag1(rtag1), .rtag2(rtag2),
        .wa(wa), .wvalid(wvalid), .wd(wd), .wtag(wtag),
        .ia(ia), .ivalid(ivalid), .itag(itag), .flush(flush)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wvalid = '0; wa = '0; wd = '0; wtag = '0;
        ivalid = '0; ia = '0; itag = '0;
        flush  = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rs1 = '0; rs2 = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        for (int r = 0; r < 32; r++) begin
            rs1[0] = creg_addr_t'(r);
            rs2[1] = creg_addr_t'(r);
            #2;
            check($sformatf("reset_rd1_r%0d", r), rd1[0], 64'h0);
            check($sformatf("reset_rd2_r%0d", r), rd2[1], 64'h0);
            check($sformatf("reset_busy_r%0d", r), 64'(rbusy1[0]), 64'h0);
            check($sformatf("reset_tag_r%0d", r), 64'(rtag2[1]), 64'h0);
        end

        // r0 write is dropped, both bypass and array
        rs1[0] = 5'd0;
        wvalid[0] = 1'b1; wa[0] = 5'd0; wd[0] = 64'hDEAD;
        #2 check("r0_bypass", rd1[0], 64'h0);
        tick(); idle();
        #2 check("r0_array", rd1[0], 64'h0);

        // same-cycle bypass of r5, then array holds it
        rs1[0] = 5'd5;
        wvalid[0] = 1'b1; wa[0] = 5'd5; wd[0] = 64'h1234;
        #2 check("r5_bypass", rd1[0], 64'h1234);
        tick(); idle();
        #2 check("r5_array", rd1[0], 64'h1234);

        // dual write to r7: port 1 wins
        rs2[1] = 5'd7;
        wvalid = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'hAA; wd[1] = 64'hBB;
        #2 check("r7_bypass_prio", rd2[1], 64'hBB);
        tick(); idle();
        #2 check("r7_array_prio", rd2[1], 64'hBB);

        // WAW on r3: issue tag 2 then tag 5
        rs1[1] = 5'd3;
        ivalid[0] = 1'b1; ia[0] = 5'd3; itag[0] = 4'd2;
        tick(); idle();
        #2 check("r3_busy_t2", 64'(rtag1[1]), 64'd2);
        ivalid[1] = 1'b1; ia[1] = 5'd3; itag[1] = 4'd5;
        tick(); idle();
        #2 check("r3_busy", 64'(rbusy1[1]), 64'd1);
        check("r3_tag5", 64'(rtag1[1]), 64'd5);
        wvalid[0] = 1'b1; wa[0] = 5'd3; wtag[0] = 4'd2; wd[0] = 64'h33;
        #2 check("r3_stale_busy_now", 64'(rbusy1[1]), 64'd1);
        check("r3_stale_tag_now", 64'(rtag1[1]), 64'd5);
        check("r3_stale_bypass", rd1[1], 64'h33);
        tick(); idle();
        #2 check("r3_stale_data", rd1[1], 64'h33);
        check("r3_stale_busy", 64'(rbusy1[1]), 64'd1);
        check("r3_stale_tag", 64'(rtag1[1]), 64'd5);
        wvalid[1] = 1'b1; wa[1] = 5'd3; wtag[1] = 4'd5; wd[1] = 64'h55;
        #2 check("r3_match_busy_now", 64'(rbusy1[1]), 64'd0);
        check("r3_match_tag_now", 64'(rtag1[1]), 64'd0);
        tick(); idle();
        #2 check("r3_cleared_busy", 64'(rbusy1[1]), 64'd0);
        check("r3_cleared_data", rd1[1], 64'h55);

        // two issues to r10 in one cycle: port 1 tag wins
        rs2[0] = 5'd10;
        ivalid = 2'b11; ia[0] = 5'd10; ia[1] = 5'd10; itag[0] = 4'd1; itag[1] = 4'd6;
        tick(); idle();
        #2 check("r10_issue_prio", 64'(rtag2[0]), 64'd6);

        // issue and matching writeback to r9 in the same cycle
        rs1[0] = 5'd9;
        ivalid[0] = 1'b1; ia[0] = 5'd9; itag[0] = 4'd4;
        wvalid[0] = 1'b1; wa[0] = 5'd9; wtag[0] = 4'd4; wd[0] = 64'h99;
        #2 check("r9_same_cycle_busy", 64'(rbusy1[0]), 64'd0);
        tick(); idle();
        #2 check("r9_next_busy", 64'(rbusy1[0]), 64'd1);
        check("r9_next_tag", 64'(rtag1[0]), 64'd4);
        check("r9_data", rd1[0], 64'h99);

        // flush with r1, r2, r4 busy plus an issue and a writeback in the flush cycle
        rs1[0] = 5'd1; rs1[1] = 5'd2; rs2[0] = 5'd4; rs2[1] = 5'd6;
        ivalid = 2'b11; ia[0] = 5'd1; itag[0] = 4'd1; ia[1] = 5'd2; itag[1] = 4'd2;
        tick(); idle();
        ivalid[0] = 1'b1; ia[0] = 5'd4; itag[0] = 4'd3;
        tick(); idle();
        #2 check("pre_flush_r1", 64'(rbusy1[0]), 64'd1);
        check("pre_flush_r2", 64'(rbusy1[1]), 64'd1);
        check("pre_flush_r4", 64'(rbusy2[0]), 64'd1);
        flush = 1'b1;
        ivalid[0] = 1'b1; ia[0] = 5'd6; itag[0] = 4'd7;
        wvalid[0] = 1'b1; wa[0] = 5'd4; wtag[0] = 4'd0; wd[0] = 64'h77;
        tick(); idle();
        #2 check("flush_r1", 64'(rbusy1[0]), 64'd0);
        check("flush_r2", 64'(rbusy1[1]), 64'd0);
        check("flush_r4", 64'(rbusy2[0]), 64'd0);
        check("flush_r4_tag", 64'(rtag2[0]), 64'd0);
        check("flush_r6", 64'(rbusy2[1]), 64'd0);
        check("flush_r4_data", rd2[0], 64'h77);

        // reset dominates a concurrent write and issue
        rs1[0] = 5'd5; rs1[1] = 5'd11;
        reset = 1'b1;
        wvalid[0] = 1'b1; wa[0] = 5'd5; wd[0] = 64'hFFFF;
        ivalid[0] = 1'b1; ia[0] = 5'd11; itag[0] = 4'd9;
        tick(); idle();
        reset = 1'b0;
        #2 check("reset_dom_data", rd1[0], 64'h0);
        check("reset_dom_busy", 64'(rbusy1[1]), 64'd0);
        rs1[0] = 5'd7;
        #2 check("reset_r7_data", rd1[0], 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
